mine_ctrl: RTL and testbench
============================

# mine_ctrl

Sequential game controller that sits directly upstream of the combinational `board` array. It holds the bomb, reveal and cursor grids in registers and drives them into `board`, along with the `move`/`dir` controls. It consumes `board`'s `states` and `nextCursorGrid` to commit cursor moves, reveal cells (with optional zero-region flood fill), and detect win or loss. Player commands arrive as single-cycle request pulses.

## Interface
Parameters:
- `GRID_SIZE`, 3: grid edge length; the grid has N = GRID_SIZE*GRID_SIZE cells.
- `STATE_SIZE`, 4: bits per cell state from `board`; value 9 means bomb.

Ports:
- `clk`  in  1  single clock; all registers are on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `bomb_load`  in  1  pulse: load `bomb_in` and start a new game (accepted in any state).
- `bomb_in`  in  N  bomb layout; bit k set means cell k is a bomb.
- `move_req`  in  1  pulse: move the cursor one cell in direction `req_dir`.
- `req_dir`  in  2  direction: 00 right, 01 up, 10 left, 11 down.
- `reveal_req`  in  1  pulse: reveal the cell under the cursor.
- `states`  in  STATE_SIZE*N  per-cell state from `board`.
- `nextCursorGrid`  in  N  candidate cursor grid from `board`.
- `bombGrid`, `revealGrid`, `cursorGrid`  out  N  registered grids, to `board`.
- `move`  out  1  combinational; tells `board` to shift the cursor.
- `dir`  out  2  combinational; equals `req_dir`.
- `game_state`  out  3  0 IDLE, 1 PLAY, 2 FLOOD, 3 WON, 4 LOST.
- `busy`  out  1  high in FLOOD.
- `cursor_err`  out  1  sticky; set when `nextCursorGrid` is not one-hot during a move.

## Operation
- Cell index k = row*GRID_SIZE + col. Row 0 is the bottom row; col 0 is the rightmost column.
- IDLE: all grids are 0; all requests are ignored except `bomb_load`.
- `bomb_load`, in any state, has top priority:
  - `bombGrid` <= `bomb_in`.
  - `revealGrid` <= 0.
  - `cursorGrid` <= one-hot bit N-1 (top-left).
  - `cursor_err` <= 0.
  - Next state is PLAY.
- PLAY, with `reveal_req` and `move_req` in the same cycle: reveal wins and the move is dropped.
- PLAY, move handling:
  - A move is blocked at the grid edge. Right is blocked at col 0, left at col GRID_SIZE-1, up at row GRID_SIZE-1, down at row 0.
  - When the move is not blocked, `move`=1 combinationally in the request cycle.
  - At that edge, `cursorGrid` <= `nextCursorGrid` if it is one-hot. Otherwise `cursorGrid` holds and `cursor_err` <= 1.
  - When the move is blocked, `move` stays 0 and nothing changes.
- PLAY, reveal of cell c (the cursor cell):
  - Already revealed: no-op.
  - `states`[c]==9: `revealGrid` <= `revealGrid` | `bombGrid`; go to LOST.
  - `states`[c]==0, with flood enabled: set bit c; go to FLOOD.
  - Otherwise: set bit c, then run the win check.
- FLOOD, each cycle:
  - grow = every unrevealed, non-bomb cell that is 8-adjacent to a revealed cell whose state is 0.
  - If grow != 0: `revealGrid` |= grow; stay in FLOOD.
  - Else: run the win check.
  - Requests are dropped while in FLOOD.
- Win check: if (`revealGrid` | `bombGrid`) == all ones, go to WON; otherwise go to PLAY.
- WON and LOST: grids are frozen; only `bomb_load` or `reset` leaves these states.

## Timing
- Reset values:
  - `game_state`=IDLE.
  - `bombGrid`, `revealGrid`, `cursorGrid` = 0.
  - `cursor_err`=0, `busy`=0.
  - `move`=0 (IDLE).
- A reset that lands mid-FLOOD or mid-move aborts immediately; the move is not committed.
- Move latency: `cursorGrid` updates at the edge ending the request cycle, visible 1 cycle later.
- Reveal latency: `revealGrid` is visible 1 cycle after the request; `game_state` (WON, LOST or FLOOD) is visible at the same time.
- FLOOD takes at most N cycles, plus 1 cycle for the no-growth check.
- Requests must be single-cycle pulses. A held request is re-executed every cycle.

## Configuration
- `MINE_FLOOD_EN` defined: zero-cell reveals enter FLOOD as described above.
- Not defined:
  - The FLOOD state and grow logic are removed.
  - A zero-cell reveal sets only bit c and runs the win check in the same cycle.
  - `busy` is tied to 0.

## Test plan
- Startup and move: reset, then `bomb_load` with `bomb_in`=9'b000000001 -> `cursorGrid`=9'b100000000 and PLAY. Then `move_req`, dir 01 (blocked) -> `move`=0, cursor unchanged. Then dir 00 -> `move`=1 and `cursorGrid`=9'b010000000 the next cycle.
- Flood win (`MINE_FLOOD_EN`): same bombs, reveal at cell 8, checked cycle by cycle:
  - `revealGrid`=9'b100000000, state FLOOD.
  - Next: 9'b110110000.
  - Next: 9'b111111110.
  - Next: WON.
- Loss: `bomb_in`=9'b100000000, reveal at the start cursor -> `revealGrid`=9'b100000000 and LOST; later move and reveal pulses cause no change.
- Simultaneous requests: in PLAY, `move_req` and `reveal_req` pulsed together -> the reveal occurs, `move`=0, cursor unchanged.
- Non-one-hot cursor: force `nextCursorGrid`=0 during a legal move -> `cursorGrid` holds, `cursor_err`=1; a subsequent `bomb_load` clears `cursor_err`.
- Reset mid-FLOOD: assert `reset` during the second FLOOD cycle -> next cycle IDLE, all grids 0, `busy`=0.

Source files
------------

// File: rtl/mine_ctrl.sv
// Minesweeper game controller: holds bomb/reveal/cursor grids and drives the board array.
// Optional zero-region flood fill is enabled by defining MINE_FLOOD_EN.
module mine_ctrl #(
    parameter int unsigned GRID_SIZE  = 3,
    parameter int unsigned STATE_SIZE = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  bomb_load,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]        bomb_in,
    input  logic                                  move_req,
    input  logic [1:0]                            req_dir,
    input  logic                                  reveal_req,
    input  logic [STATE_SIZE*GRID_SIZE*GRID_SIZE-1:0] states,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]        nextCursorGrid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]        bombGrid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]        revealGrid,
    output logic [GRID_SIZE*GRID_SIZE-1:0]        cursorGrid,
    output logic                                  move,
    output logic [1:0]                            dir,
    output logic [2:0]                            game_state,
    output logic                                  busy,
    output logic                                  cursor_err
);

    localparam int unsigned N = GRID_SIZE * GRID_SIZE;
    localparam int G = int'(GRID_SIZE);
    localparam logic [N-1:0] ALL_ONES = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_FLOOD = 3'd2,
        S_WON   = 3'd3,
        S_LOST  = 3'd4
    } state_t;

    // Cells on the edge that blocks a move in direction d.
    function automatic logic [N-1:0] edge_mask(input logic [1:0] d);
        logic [N-1:0] m;
        logic         hit;
        m = '0;
        for (int k = 0; k < int'(N); k++) begin
            case (d)
                2'b00:   hit = (k % G) == 0;
                2'b01:   hit = (k / G) == G - 1;
                2'b10:   hit = (k % G) == G - 1;
                default: hit = (k / G) == 0;
            endcase
            if (hit) m = m | (N'(1) << k);
        end
        return m;
    endfunction

`ifdef MINE_FLOOD_EN
    function automatic logic [N-1:0] nbr_mask(input int k);
        logic [N-1:0] m;
        int           r;
        int           c;
        m = '0;
        r = k / G;
        c = k % G;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < G &&
                    (c + dc) >= 0 && (c + dc) < G)
                    m = m | (N'(1) << ((r + dr) * G + c + dc));
            end
        end
        return m;
    endfunction
`endif

    state_t         r_state, w_state_nxt;
    logic [N-1:0]   r_bomb, r_reveal, r_cursor;
    logic [N-1:0]   w_bomb_nxt, w_reveal_nxt, w_cursor_nxt;
    logic           r_err, w_err_nxt;
    logic [N-1:0]   w_is_bomb_state;
    logic           w_move;
    logic           w_blocked;
    logic           w_cur_revealed;
    logic           w_cur_bomb;
`ifdef MINE_FLOOD_EN
    logic [N-1:0]   w_is_zero;
    logic [N-1:0]   w_grow;
    logic           w_cur_zero;
`endif

    // Per-cell decode of board state, plus flood growth candidates.
    for (genvar k = 0; k < int'(N); k++) begin : g_cell
        assign w_is_bomb_state[k] = states[k*STATE_SIZE +: STATE_SIZE] == STATE_SIZE'(9);
`ifdef MINE_FLOOD_EN
        localparam logic [N-1:0] NBR = nbr_mask(k);
        assign w_is_zero[k] = states[k*STATE_SIZE +: STATE_SIZE] == '0;
        assign w_grow[k]    = ~r_reveal[k] & ~r_bomb[k] & (|(w_is_zero & r_reveal & NBR));
`endif
    end

    assign w_blocked      = |(r_cursor & edge_mask(req_dir));
    assign w_cur_revealed = |(r_cursor & r_reveal);
    assign w_cur_bomb     = |(r_cursor & w_is_bomb_state);
`ifdef MINE_FLOOD_EN
    assign w_cur_zero     = |(r_cursor & w_is_zero);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_bomb   <= '0;
            r_reveal <= '0;
            r_cursor <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bomb   <= w_bomb_nxt;
            r_reveal <= w_reveal_nxt;
            r_cursor <= w_cursor_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Next-state and grid update; bomb_load overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_bomb_nxt   = r_bomb;
        w_reveal_nxt = r_reveal;
        w_cursor_nxt = r_cursor;
        w_err_nxt    = r_err;
        w_move       = 1'b0;
        if (bomb_load) begin
            w_bomb_nxt   = bomb_in;
            w_reveal_nxt = '0;
            w_cursor_nxt = N'(1) << (N - 1);
            w_err_nxt    = 1'b0;
            w_state_nxt  = S_PLAY;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (reveal_req) begin
                        if (!w_cur_revealed) begin
                            if (w_cur_bomb) begin
                                w_reveal_nxt = r_reveal | r_bomb;
                                w_state_nxt  = S_LOST;
                            end else
`ifdef MINE_FLOOD_EN
                            if (w_cur_zero) begin
                                w_reveal_nxt = r_reveal | r_cursor;
                                w_state_nxt  = S_FLOOD;
                            end else
`endif
                            begin
                                w_reveal_nxt = r_reveal | r_cursor;
                                w_state_nxt  = ((w_reveal_nxt | r_bomb) == ALL_ONES) ? S_WON : S_PLAY;
                            end
                        end
                    end else if (move_req && !w_blocked) begin
                        w_move = 1'b1;
                        if ($onehot(nextCursorGrid)) w_cursor_nxt = nextCursorGrid;
                        else                         w_err_nxt    = 1'b1;
                    end
                end
`ifdef MINE_FLOOD_EN
                S_FLOOD: begin
                    if (w_grow != '0) w_reveal_nxt = r_reveal | w_grow;
                    else w_state_nxt = ((r_reveal | r_bomb) == ALL_ONES) ? S_WON : S_PLAY;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bombGrid   = r_bomb;
    assign revealGrid = r_reveal;
    assign cursorGrid = r_cursor;
    assign cursor_err = r_err;
    assign game_state = 3'(r_state);
    assign move       = w_move;
    assign dir        = req_dir;
`ifdef MINE_FLOOD_EN
    assign busy       = (r_state == S_FLOOD);
`else
    assign busy       = 1'b0;
`endif

endmodule

// File: tb/tb_mine_ctrl.sv
// Testbench for mine_ctrl: board model, directed vector table, corner sequences and random run.
module tb_mine_ctrl;

    localparam int G  = 3;
    localparam int N  = 9;
    localparam int SS = 4;
`ifdef MINE_FLOOD_EN
    localparam bit FLOOD = 1'b1;
`else
    localparam bit FLOOD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b0, bomb_load = 1'b0, move_req = 1'b0, reveal_req = 1'b0;
    logic [1:0]      req_dir = 2'b00;
    logic [N-1:0]    bomb_in = '0;
    logic [SS*N-1:0] states;
    logic [N-1:0]    nextCursorGrid;
    logic [N-1:0]    bombGrid, revealGrid, cursorGrid;
    logic            move, busy, cursor_err;
    logic [1:0]      dir;
    logic [2:0]      game_state;
    logic            force_bad = 1'b0;
    logic            s_move;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mine_ctrl #(.GRID_SIZE(G), .STATE_SIZE(SS)) dut (
        .clk(clk), .reset(reset), .bomb_load(bomb_load), .bomb_in(bomb_in),
        .move_req(move_req), .req_dir(req_dir), .reveal_req(reveal_req),
        .states(states), .nextCursorGrid(nextCursorGrid),
        .bombGrid(bombGrid), .revealGrid(revealGrid), .cursorGrid(cursorGrid),
        .move(move), .dir(dir), .game_state(game_state), .busy(busy),
        .cursor_err(cursor_err)
    );

    function automatic logic bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // Minesweeper cell value: 9 for a bomb, else number of bombs among 8 neighbours.
    function automatic int cell_state(input logic [N-1:0] b, input int r, input int c);
        int cnt;
        if (bit_at(b, r*G + c)) return 9;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && r+dr >= 0 && r+dr < G && c+dc >= 0 && c+dc < G)
                    if (bit_at(b, (r+dr)*G + c + dc)) cnt++;
        return cnt;
    endfunction

    // Stand-in for the downstream board array.
    always_comb begin
        states = '0;
        for (int k = 0; k < N; k++)
            states = states | ((SS*N)'(cell_state(bombGrid, k / G, k % G)) << (k*SS));
        case (req_dir)
            2'b00:   nextCursorGrid = cursorGrid >> 1;
            2'b01:   nextCursorGrid = cursorGrid << G;
            2'b10:   nextCursorGrid = cursorGrid << 1;
            default: nextCursorGrid = cursorGrid >> G;
        endcase
        if (force_bad) nextCursorGrid = '0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 30) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic rst, input logic bl, input logic [N-1:0] bin, input logic mv,
                        input logic [1:0] d, input logic rv, input logic fb);
        reset = rst; bomb_load = bl; bomb_in = bin; move_req = mv; req_dir = d;
        reveal_req = rv; force_bad = fb;
        @(negedge clk);
        s_move = move;
        @(posedge clk);
        #1;
        reset = 1'b0; bomb_load = 1'b0; move_req = 1'b0; reveal_req = 1'b0; force_bad = 1'b0;
    endtask

    // Reference game model: cursor as row/col, states from neighbour counts.
    int           m_st = 0;
    logic [N-1:0] m_bomb = '0, m_rev = '0;
    int           m_cr = 0, m_cc = 0;
    logic         m_err = 1'b0, m_move = 1'b0;

    function automatic logic [N-1:0] m_cur();
        if (m_st == 0) return '0;
        return N'(1) << (m_cr*G + m_cc);
    endfunction

    task automatic model_step(input logic rst, input logic bl, input logic [N-1:0] bin,
                              input logic mv, input logic [1:0] d, input logic rv, input logic fb);
        int nr, nc, k, sv;
        logic [N-1:0] grow;
        nr = m_cr; nc = m_cc;
        case (d)
            2'b00:   nc = m_cc - 1;
            2'b01:   nr = m_cr + 1;
            2'b10:   nc = m_cc + 1;
            default: nr = m_cr - 1;
        endcase
        m_move = (m_st == 1) && !bl && mv && !rv && nr >= 0 && nr < G && nc >= 0 && nc < G;
        if (rst) begin
            m_st = 0; m_bomb = '0; m_rev = '0; m_err = 1'b0;
        end else if (bl) begin
            m_st = 1; m_bomb = bin; m_rev = '0; m_err = 1'b0; m_cr = G-1; m_cc = G-1;
        end else if (m_st == 1) begin
            if (rv) begin
                k = m_cr*G + m_cc;
                sv = cell_state(m_bomb, m_cr, m_cc);
                if (!bit_at(m_rev, k)) begin
                    m_rev = m_rev | (N'(1) << k);
                    if (sv == 9) begin
                        m_rev = m_rev | m_bomb; m_st = 4;
                    end else if (FLOOD && sv == 0) m_st = 2;
                    else if ((m_rev | m_bomb) == '1) m_st = 3;
                end
            end else if (m_move) begin
                if (fb) m_err = 1'b1;
                else begin m_cr = nr; m_cc = nc; end
            end
        end else if (m_st == 2) begin
            grow = '0;
            for (int j = 0; j < N; j++)
                if (!bit_at(m_rev, j) && !bit_at(m_bomb, j))
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++) begin
                            nr = j / G + dr; nc = j % G + dc;
                            if (!(dr == 0 && dc == 0) && nr >= 0 && nr < G && nc >= 0 && nc < G)
                                if (bit_at(m_rev, nr*G + nc) && cell_state(m_bomb, nr, nc) == 0)
                                    grow = grow | (N'(1) << j);
                        end
            if (grow != '0) m_rev = m_rev | grow;
            else m_st = ((m_rev | m_bomb) == '1) ? 3 : 1;
        end
    endtask

    typedef struct {
        logic rst; logic bl; logic [N-1:0] bin; logic mv; logic [1:0] d; logic rv; logic fb;
        logic [2:0] st; logic [N-1:0] rev; logic [N-1:0] cur; logic mvo; logic err;
    } vec_t;

    localparam int NV = 22;
    vec_t tv [NV];

    initial begin
        logic rst, bl, mv, rv, fb;
        logic [1:0] d;
        logic [N-1:0] bin;

        //          rst   bl    bin           mv    d      rv    fb    st    rev           cur           mvo   err
        tv[0]  = '{1'b1, 1'b0, 9'b000000000, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 9'b000000000, 9'b000000000, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 9'b000000000, 1'b1, 2'b01, 1'b1, 1'b0, 3'd0, 9'b000000000, 9'b000000000, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 9'b000000001, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1, 9'b000000000, 9'b100000000, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 9'b000000000, 1'b1, 2'b01, 1'b0, 1'b0, 3'd1, 9'b000000000, 9'b100000000, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 9'b000000000, 1'b1, 2'b00, 1'b0, 1'b0, 3'd1, 9'b000000000, 9'b010000000, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 9'b000000000, 1'b1, 2'b10, 1'b0, 1'b0, 3'd1, 9'b000000000, 9'b100000000, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 1'b0, 9'b000000000, 1'b1, 2'b10, 1'b0, 1'b0, 3'd1, 9'b000000000, 9'b100000000, 1'b0, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 9'b000000000, 1'b1, 2'b11, 1'b0, 1'b0, 3'd1, 9'b000000000, 9'b000100000, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 9'b000000000, 1'b1, 2'b00, 1'b0, 1'b0, 3'd1, 9'b000000000, 9'b000010000, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 9'b000000000, 1'b1, 2'b00, 1'b1, 1'b0, 3'd1, 9'b000010000, 9'b000010000, 1'b0, 1'b0};
        tv[10] = '{1'b0, 1'b0, 9'b000000000, 1'b0, 2'b00, 1'b1, 1'b0, 3'd1, 9'b000010000, 9'b000010000, 1'b0, 1'b0};
        tv[11] = '{1'b0, 1'b0, 9'b000000000, 1'b1, 2'b01, 1'b0, 1'b1, 3'd1, 9'b000010000, 9'b000010000, 1'b1, 1'b1};
        tv[12] = '{1'b0, 1'b0, 9'b000000000, 1'b1, 2'b11, 1'b0, 1'b0, 3'd1, 9'b000010000, 9'b000000010, 1'b1, 1'b1};
        tv[13] = '{1'b0, 1'b1, 9'b100000000, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1, 9'b000000000, 9'b100000000, 1'b0, 1'b0};
        tv[14] = '{1'b0, 1'b0, 9'b000000000, 1'b0, 2'b00, 1'b1, 1'b0, 3'd4, 9'b100000000, 9'b100000000, 1'b0, 1'b0};
        tv[15] = '{1'b0, 1'b0, 9'b000000000, 1'b1, 2'b00, 1'b0, 1'b0, 3'd4, 9'b100000000, 9'b100000000, 1'b0, 1'b0};
        tv[16] = '{1'b0, 1'b0, 9'b000000000, 1'b0, 2'b00, 1'b1, 1'b0, 3'd4, 9'b100000000, 9'b100000000, 1'b0, 1'b0};
        tv[17] = '{1'b0, 1'b1, 9'b011111111, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1, 9'b000000000, 9'b100000000, 1'b0, 1'b0};
        tv[18] = '{1'b0, 1'b0, 9'b000000000, 1'b0, 2'b00, 1'b1, 1'b0, 3'd3, 9'b100000000, 9'b100000000, 1'b0, 1'b0};
        tv[19] = '{1'b0, 1'b0, 9'b000000000, 1'b1, 2'b00, 1'b0, 1'b0, 3'd3, 9'b100000000, 9'b100000000, 1'b0, 1'b0};
        tv[20] = '{1'b0, 1'b1, 9'b000000001, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1, 9'b000000000, 9'b100000000, 1'b0, 1'b0};
        tv[21] = '{1'b1, 1'b0, 9'b000000000, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 9'b000000000, 9'b000000000, 1'b0, 1'b0};

        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            tick(tv[i].rst, tv[i].bl, tv[i].bin, tv[i].mv, tv[i].d, tv[i].rv, tv[i].fb);
            chk($sformatf("v%0d_move", i),  32'(s_move),      32'(tv[i].mvo));
            chk($sformatf("v%0d_state", i), 32'(game_state),  32'(tv[i].st));
            chk($sformatf("v%0d_rev", i),   32'(revealGrid),  32'(tv[i].rev));
            chk($sformatf("v%0d_cur", i),   32'(cursorGrid),  32'(tv[i].cur));
            chk($sformatf("v%0d_err", i),   32'(cursor_err),  32'(tv[i].err));
            chk($sformatf("v%0d_busy", i),  32'(busy),        32'(0));
        end

        // Reveal of a zero cell at the start cursor with one bomb in the corner.
        tick(1'b0, 1'b1, 9'b000000001, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b1, 1'b0);
        chk("fl_rev0", 32'(revealGrid), 32'(9'b100000000));
`ifdef MINE_FLOOD_EN
        chk("fl_st0", 32'(game_state), 32'(2));
        chk("fl_busy0", 32'(busy), 32'(1));
        tick(1'b0, 1'b0, '0, 1'b1, 2'b00, 1'b1, 1'b0);
        chk("fl_rev1", 32'(revealGrid), 32'(9'b110110000));
        chk("fl_st1", 32'(game_state), 32'(2));
        chk("fl_cur1", 32'(cursorGrid), 32'(9'b100000000));
        tick(1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("fl_rev2", 32'(revealGrid), 32'(9'b111111110));
        chk("fl_st2", 32'(game_state), 32'(2));
        tick(1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("fl_st3", 32'(game_state), 32'(3));
        chk("fl_rev3", 32'(revealGrid), 32'(9'b111111110));
        chk("fl_busy3", 32'(busy), 32'(0));
`else
        chk("fl_st0", 32'(game_state), 32'(1));
        chk("fl_busy0", 32'(busy), 32'(0));
        tick(1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("fl_rev1", 32'(revealGrid), 32'(9'b100000000));
        chk("fl_st1", 32'(game_state), 32'(1));
`endif

        // Reset landing in the second flood cycle aborts everything.
        tick(1'b0, 1'b1, 9'b000000001, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b1, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b0);
`ifdef MINE_FLOOD_EN
        chk("rf_pre_rev", 32'(revealGrid), 32'(9'b110110000));
        chk("rf_pre_busy", 32'(busy), 32'(1));
`endif
        tick(1'b1, 1'b0, '0, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("rf_st", 32'(game_state), 32'(0));
        chk("rf_bomb", 32'(bombGrid), 32'(0));
        chk("rf_rev", 32'(revealGrid), 32'(0));
        chk("rf_cur", 32'(cursorGrid), 32'(0));
        chk("rf_busy", 32'(busy), 32'(0));
        chk("rf_err", 32'(cursor_err), 32'(0));

        // Randomized play against the reference model.
        for (int i = 0; i < 3000; i++) begin
            rst = (i == 0) || ($urandom_range(199) == 0);
            bl  = ($urandom_range(39) == 0);
            bin = N'($urandom & $urandom & $urandom);
            mv  = $urandom_range(1);
            d   = 2'($urandom_range(3));
            rv  = ($urandom_range(3) == 0);
            fb  = ($urandom_range(15) == 0);
            model_step(rst, bl, bin, mv, d, rv, fb);
            tick(rst, bl, bin, mv, d, rv, fb);
            chk($sformatf("r%0d_move", i),  32'(s_move),     32'(m_move));
            chk($sformatf("r%0d_state", i), 32'(game_state), 32'(m_st));
            chk($sformatf("r%0d_bomb", i),  32'(bombGrid),   32'(m_bomb));
            chk($sformatf("r%0d_rev", i),   32'(revealGrid), 32'(m_rev));
            chk($sformatf("r%0d_cur", i),   32'(cursorGrid), 32'(m_cur()));
            chk($sformatf("r%0d_err", i),   32'(cursor_err), 32'(m_err));
            chk($sformatf("r%0d_busy", i),  32'(busy),       32'(m_st == 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
